// File: rtl/control_unit.sv
// Control unit for a byte-wide parallel I/O channel. It handles selection, the
// command byte, initial and ending status, and data in both directions.
// Received bytes go out on an AXI-Stream master; bytes to send arrive on an
// AXI-Stream slave. Every output is registered.
// Optional feature: CONTROL_UNIT_SHORT_BUSY_EN adds the short-busy response
// for a selection that arrives while the device is busy.
module control_unit #(
    parameter logic [7:0] DEVICE_ADDRESS = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a_bus_out,
    output logic [7:0] a_bus_in,
    input  logic       a_operational_out,
    input  logic       a_address_out,
    input  logic       a_select_out,
    input  logic       a_hold_out,
    input  logic       a_command_out,
    input  logic       a_service_out,
    output logic       a_operational_in,
    output logic       a_address_in,
    output logic       a_select_in,
    output logic       a_status_in,
    output logic       a_service_in,
    input  logic       busy,
    input  logic       end_strobe,
    output logic [7:0] command,
    output logic       command_strobe,
    input  logic [7:0] data_send_tdata,
    input  logic       data_send_tvalid,
    output logic       data_send_tready,
    output logic [7:0] data_recv_tdata,
    output logic       data_recv_tvalid,
    input  logic       data_recv_tready
);

    localparam int unsigned BW = 8;
    localparam logic [BW-1:0] ST_CE_DE = 8'h0C;
    localparam logic [BW-1:0] ST_BUSY  = 8'h10;

    typedef enum logic [3:0] {
        IDLE, PROPAGATE, ADDR_IN, CMD_WAIT, INIT_STATUS, STATUS_ACK,
        DATA, DATA_ACK, STOP_WAIT, ENDING, ENDING_ACK
`ifdef CONTROL_UNIT_SHORT_BUSY_EN
        , SHORT_BUSY
`endif
    } state_t;

    state_t        state, n_state;
    logic [BW-1:0] n_bus, n_cmd, n_rdata;
    logic          n_op, n_addr, n_sel, n_status, n_service;
    logic          n_strobe, n_tready, n_rvalid;
    logic          status_nz, n_status_nz;

    // The hold tag is not acted on by this unit
`ifdef CONTROL_UNIT_SHORT_BUSY_EN
    logic unused_inputs;
    assign unused_inputs = a_hold_out;
`else
    logic unused_inputs;
    assign unused_inputs = ^{a_hold_out, busy};
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            a_bus_in         <= '0;
            a_operational_in <= 1'b0;
            a_address_in     <= 1'b0;
            a_select_in      <= 1'b0;
            a_status_in      <= 1'b0;
            a_service_in     <= 1'b0;
            command          <= '0;
            command_strobe   <= 1'b0;
            data_send_tready <= 1'b0;
            data_recv_tdata  <= '0;
            data_recv_tvalid <= 1'b0;
            status_nz        <= 1'b0;
        end else begin
            state            <= n_state;
            a_bus_in         <= n_bus;
            a_operational_in <= n_op;
            a_address_in     <= n_addr;
            a_select_in      <= n_sel;
            a_status_in      <= n_status;
            a_service_in     <= n_service;
            command          <= n_cmd;
            command_strobe   <= n_strobe;
            data_send_tready <= n_tready;
            data_recv_tdata  <= n_rdata;
            data_recv_tvalid <= n_rvalid;
            status_nz        <= n_status_nz;
        end
    end

    // Next state and next output values
    always_comb begin
        n_state     = state;
        n_bus       = '0;
        n_op        = a_operational_in;
        n_addr      = 1'b0;
        n_sel       = 1'b0;
        n_status    = 1'b0;
        n_service   = 1'b0;
        n_cmd       = command;
        n_strobe    = 1'b0;
        n_tready    = 1'b0;
        n_rdata     = data_recv_tdata;
        n_rvalid    = data_recv_tvalid && !data_recv_tready;
        n_status_nz = status_nz;

        case (state)
            IDLE: begin
                n_op = 1'b0;
                if (a_select_out) begin
                    if (a_address_out && (a_bus_out == DEVICE_ADDRESS)) begin
`ifdef CONTROL_UNIT_SHORT_BUSY_EN
                        if (busy) begin
                            n_state  = SHORT_BUSY;
                            n_status = 1'b1;
                            n_bus    = ST_BUSY;
                        end else begin
                            n_state = ADDR_IN;
                            n_op    = 1'b1;
                            n_addr  = 1'b1;
                            n_bus   = DEVICE_ADDRESS;
                        end
`else
                        n_state = ADDR_IN;
                        n_op    = 1'b1;
                        n_addr  = 1'b1;
                        n_bus   = DEVICE_ADDRESS;
`endif
                    end else begin
                        n_state = PROPAGATE;
                        n_sel   = 1'b1;
                    end
                end
            end
            PROPAGATE: begin
                n_op = 1'b0;
                if (a_select_out) n_sel = 1'b1;
                else              n_state = IDLE;
            end
            ADDR_IN: begin
                n_op = 1'b1;
                if (a_command_out) begin
                    n_cmd    = a_bus_out;
                    n_strobe = 1'b1;
                    n_state  = CMD_WAIT;
                end else begin
                    n_addr = 1'b1;
                    n_bus  = DEVICE_ADDRESS;
                end
            end
            CMD_WAIT: begin
                if (!a_command_out) begin
                    n_state  = INIT_STATUS;
                    n_status = 1'b1;
                    n_bus    = (command == 8'h00) ? ST_CE_DE : 8'h00;
                end
            end
            INIT_STATUS: begin
                if (a_service_out) begin
                    n_state     = STATUS_ACK;
                    n_status_nz = (a_bus_in != 8'h00);
                end else begin
                    n_status = 1'b1;
                    n_bus    = a_bus_in;
                end
            end
            STATUS_ACK: begin
                if (!a_service_out) begin
                    if ((command == 8'h00) || status_nz) begin
                        n_state = IDLE;
                        n_op    = 1'b0;
                    end else begin
                        n_state = DATA;
                    end
                end
            end
            DATA: begin
                if (a_service_in) begin
                    // A request is outstanding: stop, accept, or keep holding
                    if (a_command_out) begin
                        n_state = STOP_WAIT;
                    end else if (a_service_out) begin
                        n_state = DATA_ACK;
                        if (command[0]) begin
                            n_rdata  = a_bus_out;
                            n_rvalid = 1'b1;
                        end else begin
                            n_tready = 1'b1;
                        end
                    end else begin
                        n_service = 1'b1;
                        n_bus     = command[0] ? 8'h00 : a_bus_in;
                    end
                end else if (end_strobe) begin
                    n_state  = ENDING;
                    n_status = 1'b1;
                    n_bus    = ST_CE_DE;
                end else if (command[0]) begin
                    n_service = !data_recv_tvalid;
                end else if (data_send_tvalid) begin
                    n_service = 1'b1;
                    n_bus     = data_send_tdata;
                end
            end
            DATA_ACK: begin
                if (!a_service_out) n_state = DATA;
            end
            STOP_WAIT: begin
                if (!a_command_out) begin
                    n_state  = ENDING;
                    n_status = 1'b1;
                    n_bus    = ST_CE_DE;
                end
            end
            ENDING: begin
                if (a_service_out) begin
                    n_state = ENDING_ACK;
                end else begin
                    n_status = 1'b1;
                    n_bus    = ST_CE_DE;
                end
            end
            ENDING_ACK: begin
                if (!a_service_out) begin
                    n_state = IDLE;
                    n_op    = 1'b0;
                end
            end
`ifdef CONTROL_UNIT_SHORT_BUSY_EN
            SHORT_BUSY: begin
                n_op = 1'b0;
                if (a_select_out) begin
                    n_status = 1'b1;
                    n_bus    = ST_BUSY;
                end else begin
                    n_state = IDLE;
                end
            end
`endif
            default: n_state = IDLE;
        endcase

        // Channel dropping operational-out abandons everything
        if (!a_operational_out) begin
            n_state   = IDLE;
            n_bus     = '0;
            n_op      = 1'b0;
            n_addr    = 1'b0;
            n_sel     = 1'b0;
            n_status  = 1'b0;
            n_service = 1'b0;
            n_strobe  = 1'b0;
            n_tready  = 1'b0;
            n_rvalid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes expected channel/stream
// events, a monitor pops and compares them as the unit produces them.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a_bus_out = '0;
    logic [7:0] a_bus_in;
    logic       a_operational_out = 1'b0, a_address_out = 1'b0, a_select_out = 1'b0;
    logic       a_hold_out = 1'b0, a_command_out = 1'b0, a_service_out = 1'b0;
    logic       a_operational_in, a_address_in, a_select_in, a_status_in, a_service_in;
    logic       busy = 1'b0, end_strobe = 1'b0;
    logic [7:0] command;
    logic       command_strobe;
    logic [7:0] data_send_tdata = '0;
    logic       data_send_tvalid = 1'b0;
    logic       data_send_tready;
    logic [7:0] data_recv_tdata;
    logic       data_recv_tvalid;
    logic       data_recv_tready = 1'b1;

    control_unit #(.DEVICE_ADDRESS(8'h10)) dut (
        .clk(clk), .reset(reset),
        .a_bus_out(a_bus_out), .a_bus_in(a_bus_in),
        .a_operational_out(a_operational_out), .a_address_out(a_address_out),
        .a_select_out(a_select_out), .a_hold_out(a_hold_out),
        .a_command_out(a_command_out), .a_service_out(a_service_out),
        .a_operational_in(a_operational_in), .a_address_in(a_address_in),
        .a_select_in(a_select_in), .a_status_in(a_status_in),
        .a_service_in(a_service_in),
        .busy(busy), .end_strobe(end_strobe),
        .command(command), .command_strobe(command_strobe),
        .data_send_tdata(data_send_tdata), .data_send_tvalid(data_send_tvalid),
        .data_send_tready(data_send_tready),
        .data_recv_tdata(data_recv_tdata), .data_recv_tvalid(data_recv_tvalid),
        .data_recv_tready(data_recv_tready)
    );

    always #5 clk = ~clk;

    localparam int K_ADDR = 0, K_CMD = 1, K_STAT = 2, K_SVC = 3;
    localparam int K_WDATA = 4, K_TREADY = 5, K_SEL = 6, K_OPDN = 7;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] src_q[$];
    int         checks = 0;
    int         errors = 0;

    function automatic string kname(input int k);
        case (k)
            K_ADDR:   return "addr_in";
            K_CMD:    return "command";
            K_STAT:   return "status_in";
            K_SVC:    return "service_in";
            K_WDATA:  return "recv_stream";
            K_TREADY: return "send_tready";
            K_SEL:    return "select_in";
            default:  return "oper_in_drop";
        endcase
    endfunction

    task automatic push_ev(input int k, input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input logic [15:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s got %h expected none", kname(k), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v) begin
                errors++;
                $display("FAIL event got %s=%h expected %s=%h", kname(k), v, kname(e.kind), e.val);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return a_address_in;
            1:       return a_status_in;
            2:       return a_service_in;
            3:       return a_select_in;
            default: return a_operational_in;
        endcase
    endfunction

    // Bounded wait for a unit tag to reach a level
    task automatic wait_sig(input int w, input logic v, input string name);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (sig(w) === v) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_%s got %b expected %b", name, sig(w), v);
    endtask

    function automatic logic [31:0] all_outs();
        return {a_bus_in, a_operational_in, a_address_in, a_select_in, a_status_in,
                a_service_in, command, command_strobe, data_send_tready,
                data_recv_tvalid, data_recv_tdata};
    endfunction

    // Monitor: detect unit events and compare against the scoreboard
    logic p_addr = 1'b0, p_stat = 1'b0, p_svc = 1'b0, p_sel = 1'b0, p_op = 1'b0;
    always @(negedge clk) begin
        if (!p_addr && a_address_in) check_ev(K_ADDR, {7'b0, a_operational_in, a_bus_in});
        if (command_strobe) check_ev(K_CMD, {8'b0, command});
        if (!p_stat && a_status_in) check_ev(K_STAT, {7'b0, a_operational_in, a_bus_in});
        if (!p_svc && a_service_in) check_ev(K_SVC, {8'b0, a_bus_in});
        if (data_recv_tvalid && data_recv_tready) check_ev(K_WDATA, {8'b0, data_recv_tdata});
        if (data_send_tready) check_ev(K_TREADY, {8'b0, data_send_tdata});
        if (!p_sel && a_select_in) check_ev(K_SEL, 16'h0001);
        if (p_op && !a_operational_in) check_ev(K_OPDN, 16'h0000);
        p_addr = a_address_in;
        p_stat = a_status_in;
        p_svc  = a_service_in;
        p_sel  = a_select_in;
        p_op   = a_operational_in;
    end

    // AXI-Stream source feeding bytes for read commands
    initial begin
        logic hs;
        forever begin
            @(negedge clk);
            hs = data_send_tvalid && data_send_tready;
            @(posedge clk);
            #1;
            if (hs && src_q.size() != 0) void'(src_q.pop_front());
            if (src_q.size() != 0) begin
                data_send_tvalid = 1'b1;
                data_send_tdata  = src_q[0];
            end else begin
                data_send_tvalid = 1'b0;
            end
        end
    end

    // Select the unit, hand it a command and wait for initial status
    task automatic open_cmd(input logic [7:0] cmd, input logic [7:0] stat);
        push_ev(K_ADDR, 16'h0110);
        a_select_out = 1'b1; a_address_out = 1'b1; a_bus_out = 8'h10;
        wait_sig(0, 1'b1, "addr_in_rise");
        push_ev(K_CMD, {8'h00, cmd});
        a_address_out = 1'b0; a_bus_out = cmd; a_command_out = 1'b1;
        wait_sig(0, 1'b0, "addr_in_fall");
        push_ev(K_STAT, {8'h01, stat});
        a_command_out = 1'b0; a_select_out = 1'b0; a_bus_out = 8'h00;
        wait_sig(1, 1'b1, "init_status");
    endtask

    task automatic ack_status();
        a_service_out = 1'b1;
        wait_sig(1, 1'b0, "status_drop");
        a_service_out = 1'b0;
    endtask

    initial begin
        logic [7:0] wbytes[2];
        logic [7:0] rbytes[2];
        wbytes[0] = 8'hA5; wbytes[1] = 8'h5A;
        rbytes[0] = 8'h11; rbytes[1] = 8'h22;

        // Reset state
        #1 check("reset_outputs", all_outs(), 32'h0);
        #20 reset = 1'b1;
        a_operational_out = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_outputs", all_outs(), 32'h0);

        // Control command: address, command, CE|DE status, back to idle
        open_cmd(8'h00, 8'h0C);
        push_ev(K_OPDN, 16'h0);
        ack_status();
        wait_sig(4, 1'b0, "ctl_oper_drop");

        // Other device address: selection propagates
        push_ev(K_SEL, 16'h0001);
        a_select_out = 1'b1; a_address_out = 1'b1; a_bus_out = 8'h22;
        wait_sig(3, 1'b1, "select_in_rise");
        check("prop_oper_in", 32'(a_operational_in), 32'h0);
        repeat (2) @(posedge clk);
        #1 check("prop_select_held", 32'(a_select_in), 32'h1);
        a_select_out = 1'b0;
        wait_sig(3, 1'b0, "select_in_fall");
        check("prop_oper_in_after", 32'(a_operational_in), 32'h0);
        a_address_out = 1'b0; a_bus_out = 8'h00;

        // Write command: two bytes then stop
        open_cmd(8'h01, 8'h00);
        push_ev(K_SVC, 16'h0000);
        ack_status();
        for (int i = 0; i < 2; i++) begin
            wait_sig(2, 1'b1, "wr_svc_rise");
            push_ev(K_WDATA, {8'h00, wbytes[i]});
            a_bus_out = wbytes[i]; a_service_out = 1'b1;
            wait_sig(2, 1'b0, "wr_svc_fall");
            push_ev(K_SVC, 16'h0000);
            a_service_out = 1'b0; a_bus_out = 8'h00;
        end
        wait_sig(2, 1'b1, "wr_svc_stop");
        a_command_out = 1'b1;
        wait_sig(2, 1'b0, "wr_stop_drop");
        check("stop_no_recv", 32'(data_recv_tvalid), 32'h0);
        push_ev(K_STAT, 16'h010C);
        a_command_out = 1'b0;
        wait_sig(1, 1'b1, "wr_ending");
        push_ev(K_OPDN, 16'h0);
        ack_status();
        wait_sig(4, 1'b0, "wr_oper_drop");

        // Read command: two bytes, then end_strobe racing a third byte
        src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
        open_cmd(8'h02, 8'h00);
        push_ev(K_SVC, 16'h0011);
        ack_status();
        for (int i = 0; i < 2; i++) begin
            wait_sig(2, 1'b1, "rd_svc_rise");
            push_ev(K_TREADY, {8'h00, rbytes[i]});
            a_service_out = 1'b1;
            wait_sig(2, 1'b0, "rd_svc_fall");
            if (i == 0) push_ev(K_SVC, 16'h0022);
            else begin
                end_strobe = 1'b1;
                push_ev(K_STAT, 16'h010C);
            end
            a_service_out = 1'b0;
        end
        wait_sig(1, 1'b1, "rd_ending");
        end_strobe = 1'b0;
        src_q.delete();
        push_ev(K_OPDN, 16'h0);
        ack_status();
        wait_sig(4, 1'b0, "rd_oper_drop");

        // Busy at selection
        busy = 1'b1;
`ifdef CONTROL_UNIT_SHORT_BUSY_EN
        push_ev(K_STAT, 16'h0010);
        a_select_out = 1'b1; a_address_out = 1'b1; a_bus_out = 8'h10;
        wait_sig(1, 1'b1, "short_busy");
        check("short_busy_oper", 32'(a_operational_in), 32'h0);
        a_select_out = 1'b0; a_address_out = 1'b0; a_bus_out = 8'h00;
        wait_sig(1, 1'b0, "short_busy_end");
`else
        push_ev(K_ADDR, 16'h0110);
        a_select_out = 1'b1; a_address_out = 1'b1; a_bus_out = 8'h10;
        wait_sig(0, 1'b1, "busy_ignored");
        push_ev(K_OPDN, 16'h0);
        a_operational_out = 1'b0;
        a_select_out = 1'b0; a_address_out = 1'b0; a_bus_out = 8'h00;
        wait_sig(4, 1'b0, "oper_out_abort");
        check("abort_addr_in", 32'(a_address_in), 32'h0);
        a_operational_out = 1'b1;
`endif
        busy = 1'b0;

        // Reset in the middle of a write with a received byte pending
        data_recv_tready = 1'b0;
        open_cmd(8'h01, 8'h00);
        push_ev(K_SVC, 16'h0000);
        ack_status();
        wait_sig(2, 1'b1, "rst_svc_rise");
        a_bus_out = 8'hC3; a_service_out = 1'b1;
        wait_sig(2, 1'b0, "rst_svc_fall");
        check("recv_pending", {23'h0, data_recv_tvalid, data_recv_tdata}, 32'h1C3);
        a_service_out = 1'b0; a_bus_out = 8'h00;
        repeat (3) @(posedge clk);
        #1 check("recv_backpressure", {31'h0, a_service_in}, 32'h0);
        check("recv_held", 32'(data_recv_tvalid), 32'h1);
        push_ev(K_OPDN, 16'h0);
        #2 reset = 1'b0;
        #1 check("reset_mid_outputs", all_outs(), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 check("post_reset_tags", {27'h0, a_operational_in, a_address_in,
                     a_select_in, a_status_in, a_service_in}, 32'h0);
        end
        data_recv_tready = 1'b1;

        repeat (5) @(posedge clk);
        #1 check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
